// File: rtl/irq_pending_latch_4bit.sv
// irq_pending_latch_4bit
// Request-capture stage in front of a 4-bit priority encoder. Four async
// interrupt lines are synchronised and edge/level detected into sticky
// pending bits. The masked pending vector drives the encoder, and the encoder
// result runs a single-outstanding req/ack handshake.
// Optional feature macro: IRQ_OVERRUN_CNT_EN (saturating overrun counter).
module irq_pending_latch_4bit #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [3:0]  LEVEL_MODE  = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] irq_in,
    input  logic [3:0] mask,
    input  logic [1:0] enc_Y,
    input  logic       enc_V,
    input  logic       ack,
    input  logic       ovr_clr,
    output logic [3:0] D,
    output logic [3:0] pend_raw,
    output logic       irq_req,
    output logic [1:0] irq_id,
    output logic [3:0] overrun,
    output logic [7:0] ovr_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GUARD
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [3:0] r_sync [SYNC_STAGES];
    logic [3:0] r_prev;
    logic [3:0] r_pend;
    logic [3:0] r_overrun;
    logic [1:0] r_irq_id;

    logic [3:0] w_s;
    logic [3:0] w_evt;
    logic [3:0] w_clr;
    logic [3:0] w_ovr_set;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Synchroniser chain per line plus edge-history register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= irq_in;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_prev <= w_s;
        end
    end

    // Event detect, service clear, and overrun qualification
    always_comb begin
        w_evt = (LEVEL_MODE & w_s) | (~LEVEL_MODE & w_s & ~r_prev);
        w_clr = '0;
        if (r_state == ST_REQ && ack) begin
            w_clr = 4'b0001 << r_irq_id;
        end
        // Level lines re-assert every cycle by design, so they never count as overrun
        w_ovr_set = w_evt & r_pend & ~w_clr & ~LEVEL_MODE;
    end

    // Sticky pending bits (set beats clear) and sticky overrun flags (set beats ovr_clr)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend    <= '0;
            r_overrun <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_evt;
            if (ovr_clr) begin
                r_overrun <= w_ovr_set;
            end else begin
                r_overrun <= r_overrun | w_ovr_set;
            end
        end
    end

`ifdef IRQ_OVERRUN_CNT_EN
    logic [7:0] r_ovr_count;
    logic [7:0] w_cnt_base;
    logic [2:0] w_cnt_inc;
    logic [8:0] w_cnt_sum;

    // Saturating count of overrun events; ovr_clr zeroes first, then same-cycle events add
    always_comb begin
        w_cnt_base = ovr_clr ? 8'h00 : r_ovr_count;
        w_cnt_inc  = {2'b00, w_ovr_set[0]} + {2'b00, w_ovr_set[1]}
                   + {2'b00, w_ovr_set[2]} + {2'b00, w_ovr_set[3]};
        w_cnt_sum  = {1'b0, w_cnt_base} + {6'b000000, w_cnt_inc};
    end

    // Overrun counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovr_count <= '0;
        end else begin
            r_ovr_count <= w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
        end
    end

    assign ovr_count = r_ovr_count;
`else
    assign ovr_count = 8'h00;
`endif

    // FSM state register and request index capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_irq_id <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && enc_V) begin
                r_irq_id <= enc_Y;
            end
        end
    end

    // FSM next-state: GUARD gives the encoder one cycle to see the cleared D
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (enc_V) w_state_nxt = ST_REQ;
            ST_REQ:   if (ack)   w_state_nxt = ST_GUARD;
            ST_GUARD: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        irq_req = (r_state == ST_REQ);
    end

    assign irq_id   = r_irq_id;
    assign D        = r_pend & mask;
    assign pend_raw = r_pend;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_irq_pending_latch_4bit.sv
// Scoreboard bench for irq_pending_latch_4bit: a behavioural model predicts
// the outputs after every clock edge and pushes them into a queue. A monitor
// on the falling edge pops each entry and compares it with the DUT outputs.
module tb_irq_pending_latch_4bit;

    localparam int unsigned SYNC  = 2;
    localparam logic [3:0]  LEVEL = 4'b1000;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_in;
    logic [3:0] mask;
    logic [1:0] enc_Y;
    logic       enc_V;
    logic       ack;
    logic       ovr_clr;
    logic [3:0] D;
    logic [3:0] pend_raw;
    logic       irq_req;
    logic [1:0] irq_id;
    logic [3:0] overrun;
    logic [7:0] ovr_count;

    always #5 clk = ~clk;

    irq_pending_latch_4bit #(
        .SYNC_STAGES(SYNC),
        .LEVEL_MODE (LEVEL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .mask     (mask),
        .enc_Y    (enc_Y),
        .enc_V    (enc_V),
        .ack      (ack),
        .ovr_clr  (ovr_clr),
        .D        (D),
        .pend_raw (pend_raw),
        .irq_req  (irq_req),
        .irq_id   (irq_id),
        .overrun  (overrun),
        .ovr_count(ovr_count)
    );

    // Downstream priority encoder: highest set index wins
    always_comb begin
        enc_V = |D;
        enc_Y = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (D[i]) enc_Y = 2'(i);
        end
    end

    typedef struct {
        logic [3:0] d;
        logic [3:0] pend;
        logic       req;
        logic [1:0] id;
        logic [3:0] ovr;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;

    // Reference model state: a per-line history of sampled inputs stands in
    // for the synchroniser; hist[0] is the newest sample.
    logic [3:0] hist [SYNC+1];
    logic [3:0] m_pend;
    logic [3:0] m_ovr;
    int         m_cnt;
    int         m_phase; // 0 idle, 1 requesting, 2 guard
    int         m_id;

    task automatic check(input string name, input int unsigned act,
                         input int unsigned exp, input int cyc);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        logic [3:0] s_now, p_now, d_old;
        logic       evt, clr, hit;
        int         hits;
        if (rst) begin
            for (int j = 0; j <= SYNC; j++) hist[j] = 4'h0;
            m_pend = 4'h0; m_ovr = 4'h0; m_cnt = 0; m_phase = 0; m_id = 0;
            return;
        end
        s_now = hist[SYNC-1];
        p_now = hist[SYNC];
        d_old = m_pend & mask;
        hits  = 0;
        if (ovr_clr) begin
            m_ovr = 4'h0;
            m_cnt = 0;
        end
        for (int i = 0; i < 4; i++) begin
            evt = LEVEL[i] ? s_now[i] : (s_now[i] && !p_now[i]);
            clr = (m_phase == 1) && ack && (m_id == i);
            hit = evt && m_pend[i] && !clr && !LEVEL[i];
            if (hit) begin
                m_ovr[i] = 1'b1;
                hits++;
            end
            if (evt)      m_pend[i] = 1'b1;
            else if (clr) m_pend[i] = 1'b0;
        end
`ifdef IRQ_OVERRUN_CNT_EN
        m_cnt = (m_cnt + hits > 255) ? 255 : m_cnt + hits;
`else
        m_cnt = 0;
`endif
        case (m_phase)
            0: if (d_old != 4'h0) begin
                for (int i = 0; i < 4; i++) if (d_old[i]) m_id = i;
                m_phase = 1;
            end
            1: if (ack) m_phase = 2;
            default: m_phase = 0;
        endcase
        for (int j = SYNC; j >= 1; j--) hist[j] = hist[j-1];
        hist[0] = irq_in;
    endtask

    task automatic apply(input logic [3:0] i_irq, input logic [3:0] i_mask,
                         input logic i_ack, input logic i_oc, input logic i_rst);
        exp_t e;
        irq_in = i_irq; mask = i_mask; ack = i_ack; ovr_clr = i_oc; rst = i_rst;
        @(posedge clk);
        model_step();
        cycle++;
        e.d    = m_pend & mask;
        e.pend = m_pend;
        e.req  = (m_phase == 1);
        e.id   = 2'(m_id);
        e.ovr  = m_ovr;
        e.cnt  = 8'(m_cnt);
        e.cyc  = cycle;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // Monitor: compare every presented output against the queued prediction
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("D",         D,         e.d,    e.cyc);
            check("pend_raw",  pend_raw,  e.pend, e.cyc);
            check("irq_req",   irq_req,   e.req,  e.cyc);
            check("irq_id",    irq_id,    e.id,   e.cyc);
            check("overrun",   overrun,   e.ovr,  e.cyc);
            check("ovr_count", ovr_count, e.cnt,  e.cyc);
        end
    end

    initial begin
        logic [3:0] lvl3;
        logic [3:0] rnd_irq;
        logic [3:0] rnd_mask;
        irq_in = 4'h0; mask = 4'hF; ack = 1'b0; ovr_clr = 1'b0; rst = 1'b1;
        lvl3 = 4'h0;
        for (int i = 0; i < 10; i++) model_step();

        apply(4'h0, 4'hF, 1'b0, 1'b0, 1'b1);
        apply(4'h0, 4'hF, 1'b0, 1'b0, 1'b1);
        // Single pulse on line 2, then ack the resulting request
        apply(4'b0100, 4'hF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) apply(4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) apply(4'h0, 4'hF, 1'b1, 1'b0, 1'b0);
        // Masked line 0 latches, then is exposed by unmasking
        apply(4'b0001, 4'b1110, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) apply(4'h0, 4'b1110, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) apply(4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
        // Double edge on line 1 produces an overrun, then clear it
        apply(4'b0010, 4'hF, 1'b0, 1'b0, 1'b0);
        apply(4'b0000, 4'hF, 1'b0, 1'b0, 1'b0);
        apply(4'b0010, 4'hF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) apply(4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
        apply(4'h0, 4'hF, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) apply(4'h0, 4'hF, 1'b1, 1'b0, 1'b0);
        // Line held high through reset yields one event afterwards
        apply(4'b0001, 4'hF, 1'b0, 1'b0, 1'b0);
        apply(4'b0001, 4'hF, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) apply(4'b0001, 4'hF, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) lvl3 = ~lvl3;
            rnd_irq  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            rnd_irq  = {lvl3[0], rnd_irq[2:0]};
            rnd_mask = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            apply(rnd_irq, rnd_mask,
                  $urandom_range(0, 99) < 40,
                  $urandom_range(0, 99) < 5,
                  $urandom_range(0, 199) == 0);
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0, cycle);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
